// File: rtl/traffic_ctrl_multi_if.sv
// Signal bundle between the traffic controller and its environment:
// mode requests in, lamp drives and status out.
interface traffic_ctrl_multi_if #(
    parameter int NUM_DIR = 2
);
    localparam int DW = $clog2(NUM_DIR);

    logic               FM;
    logic               TEST;
    logic [NUM_DIR-1:0] GRN;
    logic [NUM_DIR-1:0] YLW;
    logic [NUM_DIR-1:0] RED;
    logic [DW-1:0]      DIR;
    logic               FLASH;

    modport master (
        output FM, TEST,
        input  GRN, YLW, RED, DIR, FLASH
    );

    modport slave (
        input  FM, TEST,
        output GRN, YLW, RED, DIR, FLASH
    );
endinterface

// File: rtl/traffic_ctrl_multi.sv
// Round-robin traffic-light controller for NUM_DIR approaches with programmable
// phase lengths, a flashing-yellow maintenance mode and a prescaler-bypass test mode.
module traffic_ctrl_multi #(
    parameter int NUM_DIR  = 2,
    parameter int PRESCALE = 16,
    parameter int CW       = 8,
    parameter int GREEN_T  = 4,
    parameter int YELLOW_T = 2,
    parameter int ALLRED_T = 1
) (
    input  logic                  CK,
    input  logic                  CLR,
    traffic_ctrl_multi_if.slave   bus
);
    localparam int DW = $clog2(NUM_DIR);
    localparam int PW = $clog2(PRESCALE);

    typedef enum logic [1:0] {
        ST_ALLRED,
        ST_GREEN,
        ST_YELLOW,
        ST_FLASH
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   dir_q, dir_d;
    logic [CW-1:0]   timer_q, timer_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            blink_q, blink_d;
    logic            fm_q;
    logic            test_q;

    logic            tick;
    logic            expire;
    logic [CW-1:0]   dur;
    logic [NUM_DIR-1:0] grnLamp, ylwLamp, redLamp;

    // The prescaler free-runs even in test mode; test mode only forces the tick.
    assign presc_d = (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + PW'(1);
    assign tick    = test_q | (presc_q == PW'(PRESCALE - 1));

    always_comb begin
        dur = CW'(ALLRED_T);
        case (state_q)
            ST_GREEN:  dur = CW'(GREEN_T);
            ST_YELLOW: dur = CW'(YELLOW_T);
            default:   dur = CW'(ALLRED_T);
        endcase
    end

    assign expire = tick && (timer_q == dur - CW'(1));

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        blink_d = 1'b0;
        timer_d = tick ? timer_q + CW'(1) : timer_q;
        case (state_q)
            ST_ALLRED: begin
                if (expire) state_d = fm_q ? ST_FLASH : ST_GREEN;
            end
            ST_GREEN: begin
                if (fm_q || expire) state_d = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (expire) begin
                    state_d = ST_ALLRED;
                    dir_d   = (dir_q == DW'(NUM_DIR - 1)) ? '0 : dir_q + DW'(1);
                end
            end
            ST_FLASH: begin
                // Leaving flash wins over a coincident tick, so blink restarts dark.
                if (!fm_q) begin
                    state_d = ST_ALLRED;
                    dir_d   = '0;
                end else begin
                    blink_d = blink_q ^ tick;
                end
            end
            default: state_d = ST_ALLRED;
        endcase
        if (expire || (state_d != state_q) || (state_q == ST_FLASH)) timer_d = '0;
    end

    always_ff @(posedge CK) begin
        if (CLR) begin
            state_q <= ST_ALLRED;
            dir_q   <= '0;
            timer_q <= '0;
            presc_q <= '0;
            blink_q <= 1'b0;
            fm_q    <= 1'b0;
            test_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            presc_q <= presc_d;
            blink_q <= blink_d;
            fm_q    <= bus.FM;
            test_q  <= bus.TEST;
        end
    end

    // Lamps depend only on registered state, so no input reaches an output in the same cycle.
    always_comb begin
        grnLamp = '0;
        ylwLamp = '0;
        redLamp = '1;
        case (state_q)
            ST_GREEN: begin
                grnLamp[dir_q] = 1'b1;
                redLamp[dir_q] = 1'b0;
            end
            ST_YELLOW: begin
                ylwLamp[dir_q] = 1'b1;
                redLamp[dir_q] = 1'b0;
            end
            ST_FLASH: begin
                redLamp = '0;
                ylwLamp = {NUM_DIR{blink_q}};
            end
            default: ;
        endcase
    end

    assign bus.GRN   = grnLamp;
    assign bus.YLW   = ylwLamp;
    assign bus.RED   = redLamp;
    assign bus.DIR   = dir_q;
    assign bus.FLASH = (state_q == ST_FLASH);
endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed bench for traffic_ctrl_multi: a 2-approach instance for sequencing, flash,
// reset and prescaled timing, and a 4-approach instance for wrap order and lamp invariants.
module tb_traffic_ctrl_multi;
    logic CK = 1'b0;
    logic clr2;
    logic clr4;
    int   checkCount = 0;
    int   failCount  = 0;

    always #5 CK = ~CK;

    traffic_ctrl_multi_if #(.NUM_DIR(2)) bus2 ();
    traffic_ctrl_multi_if #(.NUM_DIR(4)) bus4 ();

    traffic_ctrl_multi #(.NUM_DIR(2)) dut2 (
        .CK  (CK),
        .CLR (clr2),
        .bus (bus2)
    );

    traffic_ctrl_multi #(.NUM_DIR(4)) dut4 (
        .CK  (CK),
        .CLR (clr4),
        .bus (bus4)
    );

    typedef struct {
        logic       clr;
        logic       fm;
        logic       test;
        logic [1:0] grn;
        logic [1:0] ylw;
        logic [1:0] red;
        logic       dir;
        logic       flash;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic c, input logic f, input logic t, input logic [1:0] g,
                          input logic [1:0] y, input logic [1:0] r, input logic d);
        vec_t v;
        v.clr = c; v.fm = f; v.test = t;
        v.grn = g; v.ylw = y; v.red = r; v.dir = d; v.flash = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic c, input logic f, input logic t);
        @(negedge CK);
        clr2      = c;
        bus2.FM   = f;
        bus2.TEST = t;
        @(posedge CK);
        #1;
    endtask

    task automatic applyStimulus4(input logic c, input logic f, input logic t);
        @(negedge CK);
        clr4      = c;
        bus4.FM   = f;
        bus4.TEST = t;
        @(posedge CK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] g, input logic [1:0] y,
                               input logic [1:0] r, input logic d, input logic f);
        checkCount++;
        if (bus2.GRN !== g || bus2.YLW !== y || bus2.RED !== r || bus2.DIR !== d || bus2.FLASH !== f) begin
            failCount++;
            $display("[TB] FAIL %s: got grn=%b ylw=%b red=%b dir=%0d flash=%b, want grn=%b ylw=%b red=%b dir=%0d flash=%b",
                     tag, bus2.GRN, bus2.YLW, bus2.RED, bus2.DIR, bus2.FLASH, g, y, r, d, f);
        end
    endtask

    task automatic checkValue(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
        end
    endtask

    task automatic runTable(input int first, input string tag);
        for (int i = first; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].clr, vecs[i].fm, vecs[i].test);
            checkOutput($sformatf("%s[%0d]", tag, i), vecs[i].grn, vecs[i].ylw,
                        vecs[i].red, vecs[i].dir, vecs[i].flash);
        end
    endtask

    function automatic bit lampsLegal4();
        int nonRed;
        if (bus4.FLASH) return (bus4.GRN == 4'b0) && (bus4.RED == 4'b0) &&
                               (bus4.YLW == 4'b0000 || bus4.YLW == 4'b1111);
        nonRed = 0;
        for (int i = 0; i < 4; i++) begin
            if ((int'(bus4.GRN[i]) + int'(bus4.YLW[i]) + int'(bus4.RED[i])) != 1) return 1'b0;
            if (!bus4.RED[i]) nonRed++;
        end
        return nonRed <= 1;
    endfunction

    initial begin
        int  n;
        int  g;
        int  y;
        bit  found;
        logic [3:0] prevG;
        logic [3:0] greens[$];
        logic fm;

        clr2 = 1'b1; clr4 = 1'b1;
        bus2.FM = 1'b0; bus2.TEST = 1'b0;
        bus4.FM = 1'b0; bus4.TEST = 1'b0;

        // Reset held three edges, then E0..E15 with TEST=1.
        for (int i = 0; i < 3; i++) addVec(1, 0, 1, 2'b00, 2'b00, 2'b11, 0);
        addVec(0, 0, 1, 2'b00, 2'b00, 2'b11, 0);
        for (int i = 0; i < 4; i++) addVec(0, 0, 1, 2'b01, 2'b00, 2'b10, 0);
        for (int i = 0; i < 2; i++) addVec(0, 0, 1, 2'b00, 2'b01, 2'b10, 0);
        addVec(0, 0, 1, 2'b00, 2'b00, 2'b11, 1);
        for (int i = 0; i < 4; i++) addVec(0, 0, 1, 2'b10, 2'b00, 2'b01, 1);
        for (int i = 0; i < 2; i++) addVec(0, 0, 1, 2'b00, 2'b10, 2'b01, 1);
        addVec(0, 0, 1, 2'b00, 2'b00, 2'b11, 0);
        addVec(0, 0, 1, 2'b01, 2'b00, 2'b10, 0);

        runTable(0, "seq");

        // Flash entry from mid-green, blink, and exit back to dir-0 green.
        applyStimulus(0, 0, 1); checkOutput("fm_green1", 2'b01, 2'b00, 2'b10, 0, 0);
        applyStimulus(0, 1, 1); checkOutput("fm_green2", 2'b01, 2'b00, 2'b10, 0, 0);
        applyStimulus(0, 1, 1); checkOutput("fm_yel1",   2'b00, 2'b01, 2'b10, 0, 0);
        applyStimulus(0, 1, 1); checkOutput("fm_yel2",   2'b00, 2'b01, 2'b10, 0, 0);
        applyStimulus(0, 1, 1); checkOutput("fm_allred", 2'b00, 2'b00, 2'b11, 1, 0);
        applyStimulus(0, 1, 1); checkOutput("flash0",    2'b00, 2'b00, 2'b00, 1, 1);
        applyStimulus(0, 1, 1); checkOutput("flash1",    2'b00, 2'b11, 2'b00, 1, 1);
        applyStimulus(0, 1, 1); checkOutput("flash2",    2'b00, 2'b00, 2'b00, 1, 1);
        applyStimulus(0, 0, 1); checkOutput("flash3",    2'b00, 2'b11, 2'b00, 1, 1);
        applyStimulus(0, 0, 1); checkOutput("fm_exit",   2'b00, 2'b00, 2'b11, 0, 0);
        applyStimulus(0, 0, 1); checkOutput("fm_green",  2'b01, 2'b00, 2'b10, 0, 0);

        // One-cycle reset during dir-1 yellow, then the startup sequence replays.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            applyStimulus(0, 0, 1);
            if (bus2.YLW == 2'b10 && bus2.DIR == 1'b1) found = 1'b1;
        end
        checkValue("reach_yel_dir1", int'(found), 1);
        applyStimulus(1, 0, 1); checkOutput("mid_reset", 2'b00, 2'b00, 2'b11, 0, 0);
        runTable(3, "replay");

        // Prescaled timing with TEST=0.
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 0, 0);
            n++;
            if (bus2.GRN != 2'b00) break;
        end
        checkValue("edges_to_green", n, 16);
        checkValue("first_green_dir0", int'(bus2.GRN), 1);
        g = 1;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(0, 0, 0);
            if (bus2.GRN != 2'b01) break;
            g++;
        end
        checkValue("green_cycles", g, 64);
        y = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus2.YLW != 2'b01) break;
            y++;
            applyStimulus(0, 0, 0);
        end
        checkValue("yellow_cycles", y, 32);
        checkOutput("after_yellow", 2'b00, 2'b00, 2'b11, 1, 0);
        clr2 = 1'b1;

        // Four approaches: greens in order 0,1,2,3,0.
        applyStimulus4(1, 0, 1);
        applyStimulus4(1, 0, 1);
        prevG = 4'b0;
        for (int i = 0; i < 80 && greens.size() < 5; i++) begin
            applyStimulus4(0, 0, 1);
            if (bus4.GRN != 4'b0 && prevG == 4'b0) greens.push_back(bus4.GRN);
            prevG = bus4.GRN;
        end
        checkValue("green_count4", greens.size(), 5);
        for (int k = 0; k < greens.size(); k++)
            checkValue($sformatf("green_order[%0d]", k), int'(greens[k]), 1 << (k % 4));

        // Random flash-mode toggling; lamp invariant every cycle.
        fm = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) fm = ~fm;
            applyStimulus4(0, fm, 1);
            checkCount++;
            if (!lampsLegal4()) begin
                failCount++;
                $display("[TB] FAIL invariant4[%0d]: got grn=%b ylw=%b red=%b flash=%b, want one lamp per direction",
                         i, bus4.GRN, bus4.YLW, bus4.RED, bus4.FLASH);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule

// File: doc/traffic_ctrl_multi.md
Name: traffic_ctrl_multi

Overview:
- Parametrised successor to the two-road traffic-light controller.
- Sequences NUM_DIR approaches round-robin through GREEN → YELLOW → ALL-RED.
- Phase durations are programmable, counted in prescaled time units.
- Adds a flashing-yellow maintenance mode (FM) and a TEST mode that bypasses the prescaler for fast simulation and production test.

Parameters:
- NUM_DIR, 2: number of approaches/directions; legal range 2..8.
- PRESCALE, 16: clock cycles per time unit (tick); must be ≥ 2.
- CW, 8: width of the phase timer.
- GREEN_T, 4: green duration in ticks; legal range 1..2^CW-1.
- YELLOW_T, 2: yellow duration in ticks; legal range 1..2^CW-1.
- ALLRED_T, 1: all-red clearance duration in ticks; legal range 1..2^CW-1.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- CLR  input  1  reset; synchronous, active-high.
- FM  input  1  flash-mode request; level-sensitive.
- TEST  input  1  test mode; when active, a tick occurs every cycle.
- GRN  output  NUM_DIR  green lamp per direction.
- YLW  output  NUM_DIR  yellow lamp per direction.
- RED  output  NUM_DIR  red lamp per direction.
- DIR  output  clog2(NUM_DIR)  index of the direction currently served.
- FLASH  output  1  high while in the FLASH state.

Behaviour:
- Clocking and reset:
  - One clock CK. Reset CLR is synchronous and active-high.
  - Reset state: state=ALLRED, DIR=0, timer=0, prescaler=0, fm_q=0, test_q=0, blink=0.
  - Outputs during and after reset: RED=all ones, GRN=0, YLW=0, FLASH=0.
  - CLR asserted mid-phase returns to the reset state on that edge. No lamp may glow green or yellow in the cycle after the reset edge.
- Input registers: FM and TEST are each sampled into a flop (fm_q, test_q). Only the registered versions affect control, so they have one cycle of latency.
- Tick generation:
  - Prescaler counts 0..PRESCALE-1 and wraps to 0.
  - tick = test_q OR (prescaler == PRESCALE-1).
  - The prescaler always runs, including while TEST is active.
- Timer:
  - Increments on tick.
  - "Expire" = tick AND timer == DUR-1, where DUR is the duration of the current state.
  - On expire, or on any state change, timer ← 0.
  - No arithmetic wraps, because DUR ≤ 2^CW-1.
- State machine (registered states ALLRED, GREEN, YELLOW, FLASH):
  - ALLRED: on expire, go to FLASH if fm_q=1, else go to GREEN. DIR keeps the value set when YELLOW was left.
  - GREEN: if fm_q=1, go to YELLOW on the next edge without waiting for expire (timer restarts). Otherwise go to YELLOW on expire.
  - YELLOW: always runs the full YELLOW_T. On expire, go to ALLRED; DIR ← DIR+1, wrapping from NUM_DIR-1 to 0.
  - FLASH: when fm_q=0, go to ALLRED with DIR ← 0 and timer ← 0. The exit is immediate and needs no tick.
  - Green is never entered directly from FLASH or YELLOW. The ALL-RED clearance always precedes every green.
- Lamp decode (from registered state and DIR only; no combinational input-to-output path):
  - ALLRED: RED=all ones, GRN=0, YLW=0.
  - GREEN: GRN[DIR]=1, RED[DIR]=0; all other directions RED=1.
  - YELLOW: YLW[DIR]=1, RED[DIR]=0; all other directions RED=1.
  - FLASH: GRN=0, RED=0, YLW = all bits equal to blink. blink toggles on every tick while in FLASH and is cleared on leaving FLASH. FLASH output = 1.
- Invariant checked by the bench: for each direction, exactly one of GRN/YLW/RED is 1 outside FLASH, and at most one direction is non-red.
- Simultaneous events:
  - CLR overrides FM and TEST.
  - fm_q rising in the same cycle as a GREEN expire gives YELLOW (the same single transition).
  - fm_q falling in the same cycle as a FLASH tick: the exit wins and blink clears.

Test Plan:
- Reset and lamp sequence: hold CLR=1 for 3 cycles with TEST=1, FM=0, NUM_DIR=2, defaults; release at edge E0 → RED=2'b11 through E0. GRN=2'b01 after E1. YLW=2'b01 after E5. RED=2'b11 after E7 with DIR=1. GRN=2'b10 after E8. YLW=2'b10 after E12. DIR=0 after E14.
- Prescaled timing: TEST=0, PRESCALE=16 → the first green lasts exactly 4×16=64 cycles and yellow lasts 32 cycles.
- Flash mode: TEST=1; raise FM in the middle of dir-0 green → YELLOW on the next edge, held for 2 cycles, then ALLRED for 1 cycle, then FLASH=1 with YLW toggling 2'b00/2'b11 every cycle. Drop FM → ALLRED, then green on dir 0.
- Reset mid-operation: assert CLR for one cycle during YELLOW of dir 1 → the next cycle shows RED=all ones and DIR=0; the sequence restarts exactly as in scenario 1.
- Width and wrap: NUM_DIR=4, TEST=1 → greens appear on dir 0,1,2,3 in order, then 0 again. The lamp invariant holds on every cycle over 200 cycles of random FM toggling.
